msx_mouse_bridge: RTL
=====================

MSX_MOUSE_BRIDGE -- requirements
Module: msx_mouse_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 32220, number of clk_sys cycles without a strobe edge before the phase returns to WAIT (about 1.5 ms at 21.48 MHz).
REQ-002 Port: clk_sys, input, 1, system clock; all logic is on its rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset.
REQ-004 Port: ps2_mouse, input, 25, packet bus: [24] toggles on each new packet; [0] left button; [1] right button; [4] X sign; [5] Y sign; [15:8] X magnitude; [23:16] Y magnitude.
REQ-005 Port: strobe, input, 1, MSX joystick pin-8 strobe, already in the clk_sys domain.
REQ-006 Port: data, output, 6, MSX port pins: [3:0] nibble; [4] ~left; [5] ~right.
REQ-007 Port: present, output, 1, set by the first packet, cleared only by reset.

Function
REQ-008 Packet detect: a packet SHALL be accepted when ps2_mouse[24] differs from its registered copy, one cycle after the toggle.
REQ-009 Axis deltas SHALL be the 9-bit signed values {sign, magnitude}.
- MSX X contribution = -dx.
- MSX Y contribution = +dy.
REQ-010 Each axis SHALL keep a 10-bit signed accumulator that saturates at -512 and +511.
REQ-011 Strobe edge: any change of strobe versus its registered copy (rising or falling) SHALL count as one edge.
REQ-012 Phase FSM states: WAIT, XH, XL, YH, YL.
- WAIT -edge-> XH with latch.
- XH -edge-> XL; XL -edge-> YH; YH -edge-> YL.
- YL -edge-> XH with latch (wrap).
REQ-013 Latch: each axis accumulator value SHALL be clamped to 8-bit signed (-128..127) into its output register.
- The accumulator is then loaded with that cycle's packet delta if a packet is accepted in the same cycle, else cleared.
- No packet is ever lost.
REQ-014 Nibble select:
- XH = latchX[7:4]; XL = latchX[3:0].
- YH = latchY[7:4]; YL = latchY[3:0].
- WAIT = 4'h0.
REQ-015 data SHALL be registered and SHALL update on the cycle after the edge is detected; latency from strobe edge to new data is 2 clk_sys cycles.
REQ-016 data[5:4] SHALL follow the button bits of the last accepted packet, inverted, independent of phase.
REQ-017 Timeout counter: reset to 0 on every edge; increments in any non-WAIT state.
- On reaching TIMEOUT_CYC-1 the FSM SHALL enter WAIT.
- Entering WAIT on timeout does not latch and does not clear the accumulators.
REQ-018 If an edge and a timeout occur in the same cycle, the edge SHALL win.
REQ-019 Accumulators SHALL keep integrating packets in every state, including WAIT.

Reset
REQ-020 reset SHALL set:
- phase = WAIT; timeout counter = 0.
- accumulators and latches = 0.
- button state = released; data = 6'h30; present = 0.
- Registered copies of strobe and ps2_mouse[24] = the current input values, so reset produces no spurious edge or packet.
REQ-021 A reset asserted mid-sequence SHALL abort the sequence; the next edge after release SHALL be treated as a WAIT->XH edge.

Structure
REQ-022 Package msx_mouse_pkg SHALL hold the phase enum typedef, the accumulator width (10), the latch width (8) and the default TIMEOUT_CYC.
REQ-023 Sub-module msx_mouse_axis SHALL implement one saturating accumulator with clamp-and-latch; it is instantiated once per axis.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Packet dx=+5, dy=+3, then 4 strobe edges -> nibbles F,B,0,3 (X=-5=0xFB, Y=0x03).
- Packets dx=-200 and dx=-200 (X accumulator +400) -> latched X = 0x7F; remaining accumulator = 0 after the latch.
- Packet accepted in the same cycle as the YL->XH edge -> that delta appears in the next sequence, not in the current one.
- Two edges, then TIMEOUT_CYC idle cycles -> data nibble = 0 and state WAIT; the next edge yields the X high nibble.
- Left pressed, right released -> data[4]=0 and data[5]=1 in every phase.
- Reset asserted at phase YH -> data=6'h30, present=0; the next edge latches and outputs the X high nibble.

Source files
------------

// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX mouse bridge: phase encoding,
// accumulator/latch widths and the nibble multiplexer.
package msx_mouse_pkg;

    typedef enum logic [2:0] {
        PH_WAIT = 3'd0,
        PH_XH   = 3'd1,
        PH_XL   = 3'd2,
        PH_YH   = 3'd3,
        PH_YL   = 3'd4
    } phase_e;

    localparam int ACC_W           = 10;
    localparam int LAT_W           = 8;
    localparam int TIMEOUT_CYC_DEF = 32220;

    function automatic logic [3:0] nibble_sel(input phase_e ph,
                                              input logic [LAT_W-1:0] lat_x,
                                              input logic [LAT_W-1:0] lat_y);
        logic [3:0] nib;
        case (ph)
            PH_XH:   nib = lat_x[7:4];
            PH_XL:   nib = lat_x[3:0];
            PH_YH:   nib = lat_y[7:4];
            PH_YL:   nib = lat_y[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/msx_mouse_axis.sv
// One mouse axis: saturating 10-bit accumulator that is clamped to 8 bits
// into a latch on request, then reloaded with any concurrent delta.
module msx_mouse_axis
    import msx_mouse_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             pkt_valid,
    input  logic [ACC_W-1:0] delta,
    input  logic             latch,
    output logic [LAT_W-1:0] lat_q
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [LAT_W-1:0] lat_d;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] sat_s;
    logic [LAT_W-1:0] clamp_s;

    // Accumulator and latch registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q <= {ACC_W{1'b0}};
            lat_q <= {LAT_W{1'b0}};
        end else begin
            acc_q <= acc_d;
            lat_q <= lat_d;
        end
    end

    // Saturating add, 8-bit clamp and latch/reload selection
    always_comb begin
        sum_s = {acc_q[ACC_W-1], acc_q} + {delta[ACC_W-1], delta};
        // Top two sum bits disagree only on overflow; the sign picks the rail.
        if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
            sat_s = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_s = sum_s[ACC_W-1:0];
        end

        if ((acc_q[9:7] == 3'b000) || (acc_q[9:7] == 3'b111)) begin
            clamp_s = acc_q[7:0];
        end else begin
            clamp_s = acc_q[9] ? 8'h80 : 8'h7F;
        end

        if (latch) begin
            lat_d = clamp_s;
            acc_d = pkt_valid ? delta : {ACC_W{1'b0}};
        end else begin
            lat_d = lat_q;
            acc_d = pkt_valid ? sat_s : acc_q;
        end
    end

endmodule

// File: rtl/msx_mouse_bridge.sv
// PS/2 mouse packets to MSX joystick-port mouse protocol: strobe edges step
// through X/Y high/low nibbles; an idle strobe times the sequence out.
module msx_mouse_bridge
    import msx_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic        strobe,
    output logic [5:0]  data,
    output logic        present
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    phase_e           phase_q;
    phase_e           phase_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             strobe_q;
    logic             tog_q;
    logic [1:0]       btn_q;
    logic [1:0]       btn_d;
    logic             present_q;
    logic             present_d;
    logic [5:0]       data_q;
    logic [5:0]       data_d;
    logic             strobe_edge_s;
    logic             pkt_s;
    logic             latch_s;
    logic [ACC_W-1:0] dx_s;
    logic [ACC_W-1:0] dy_s;
    logic [LAT_W-1:0] lat_x_s;
    logic [LAT_W-1:0] lat_y_s;
    logic             unused_ok;

    assign strobe_edge_s = strobe ^ strobe_q;
    assign pkt_s         = ps2_mouse[24] ^ tog_q;
    // MSX X grows leftward, so the PS/2 X delta is negated.
    assign dx_s      = {ACC_W{1'b0}} - {ps2_mouse[4], ps2_mouse[4], ps2_mouse[15:8]};
    assign dy_s      = {ps2_mouse[5], ps2_mouse[5], ps2_mouse[23:16]};
    assign unused_ok = ^{ps2_mouse[7:6], ps2_mouse[3:2]};
    assign data      = data_q;
    assign present   = present_q;

    msx_mouse_axis u_axis_x (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .pkt_valid (pkt_s),
        .delta     (dx_s),
        .latch     (latch_s),
        .lat_q     (lat_x_s)
    );

    msx_mouse_axis u_axis_y (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .pkt_valid (pkt_s),
        .delta     (dy_s),
        .latch     (latch_s),
        .lat_q     (lat_y_s)
    );

    // State register; input copies track the pins even in reset so release is edge-free
    always_ff @(posedge clk_sys) begin
        strobe_q <= strobe;
        tog_q    <= ps2_mouse[24];
        if (reset) begin
            phase_q   <= PH_WAIT;
            cnt_q     <= {CNT_W{1'b0}};
            btn_q     <= 2'b00;
            present_q <= 1'b0;
            data_q    <= 6'h30;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            present_q <= present_d;
            data_q    <= data_d;
        end
    end

    // Next phase, timeout counter and packet-derived state
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        btn_d     = pkt_s ? ps2_mouse[1:0] : btn_q;
        present_d = present_q | pkt_s;
        latch_s   = 1'b0;
        if (strobe_edge_s) begin
            cnt_d = {CNT_W{1'b0}};
            case (phase_q)
                PH_WAIT: begin phase_d = PH_XH; latch_s = 1'b1; end
                PH_XH:   phase_d = PH_XL;
                PH_XL:   phase_d = PH_YH;
                PH_YH:   phase_d = PH_YL;
                PH_YL:   begin phase_d = PH_XH; latch_s = 1'b1; end
                default: phase_d = PH_WAIT;
            endcase
        end else if (phase_q != PH_WAIT) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                phase_d = PH_WAIT;
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Output pins: inverted buttons plus the nibble of the current phase
    always_comb begin
        data_d = {~btn_q[1], ~btn_q[0], nibble_sel(phase_q, lat_x_s, lat_y_s)};
    end

endmodule
